// File: rtl/shwr_integral_seq.sv
// Shower-integral readout sequencer.
// Opens an integration window on every channel after an accepted trigger. It
// then streams each enabled channel's integral, peak, baseline and saturation
// flag, one word per accepted handshake. A hold-off period follows, during
// which the instances re-track their baselines before the next trigger can be
// accepted.
//
// Ports:
//   CLK120, RESET      clock, synchronous active-high reset
//   TRIG               shower trigger pulse
//   CH_MASK            per-channel read enable, captured on trigger acceptance
//   INTEGRAL_IN, PEAK_IN, SBASELINE_IN, SATURATED_IN
//                      packed per-channel instance results
//   INTEG_EN           TRIGGERED drive to every instance
//   HILO               constant gain select (odd channels are high gain)
//   OUT_*              readout stream (valid/ready handshake)
//   BUSY, EVT_DONE, MISSED  status: not idle, end-of-event pulse, dropped triggers
module shwr_integral_seq #(
   parameter int unsigned NCH     = 6,
   parameter int unsigned AREA_W  = 19,
   parameter int unsigned ADC_W   = 12,
   parameter int unsigned BL_W    = 14,
   parameter int unsigned WINDOW  = 264,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic                  CLK120,
   input  logic                  RESET,
   input  logic                  TRIG,
   input  logic [NCH-1:0]        CH_MASK,
   input  logic [NCH*AREA_W-1:0] INTEGRAL_IN,
   input  logic [NCH*ADC_W-1:0]  PEAK_IN,
   input  logic [NCH*BL_W-1:0]   SBASELINE_IN,
   input  logic [NCH-1:0]        SATURATED_IN,
   output logic [NCH-1:0]        INTEG_EN,
   output logic [NCH-1:0]        HILO,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [2:0]            OUT_CHAN,
   output logic [AREA_W-1:0]     OUT_INTEGRAL,
   output logic [ADC_W-1:0]      OUT_PEAK,
   output logic [BL_W-1:0]       OUT_BASELINE,
   output logic                  OUT_SAT,
   output logic                  OUT_LAST,
   output logic [7:0]            OUT_EVT,
   output logic                  BUSY,
   output logic                  EVT_DONE,
   output logic [15:0]           MISSED
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {IDLE, INTEG, READ, DONE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NCH-1:0]      mask_q, mask_d;
   // channels still to be presented after the current word
   logic [NCH-1:0]      rem_q, rem_d;
   logic [7:0]          evt_q, evt_d;
   logic [15:0]         missed_q, missed_d;
   logic [NCH-1:0]      integ_en_q, integ_en_d;
   logic                out_valid_q, out_valid_d;
   logic [2:0]          out_chan_q, out_chan_d;
   logic [AREA_W-1:0]   out_integral_q, out_integral_d;
   logic [ADC_W-1:0]    out_peak_q, out_peak_d;
   logic [BL_W-1:0]     out_baseline_q, out_baseline_d;
   logic                out_sat_q, out_sat_d;
   logic                out_last_q, out_last_d;
   logic [7:0]          out_evt_q, out_evt_d;
   logic                busy_q, busy_d;
   logic                evt_done_q, evt_done_d;

   logic                load;
   logic [NCH-1:0]      pick_src;
   logic                found;

   // Gain select is fixed by channel position.
   always_comb begin
      HILO = '0;
      for (int i = 0; i < NCH; i++) HILO[i] = (i % 2) == 1;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mask_d         = mask_q;
      rem_d          = rem_q;
      evt_d          = evt_q;
      missed_d       = missed_q;
      out_valid_d    = out_valid_q;
      out_chan_d     = out_chan_q;
      out_integral_d = out_integral_q;
      out_peak_d     = out_peak_q;
      out_baseline_d = out_baseline_q;
      out_sat_d      = out_sat_q;
      out_last_d     = out_last_q;
      out_evt_d      = out_evt_q;
      load           = 1'b0;
      pick_src       = '0;
      found          = 1'b0;

      case (state_q)
         IDLE: begin
            if (TRIG) begin
               mask_d  = CH_MASK;
               evt_d   = evt_q + 8'd1;
               cnt_d   = '0;
               state_d = INTEG;
            end
         end
         INTEG: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WINDOW - 1)) begin
               cnt_d = '0;
               if (mask_q != '0) begin
                  state_d  = READ;
                  load     = 1'b1;
                  pick_src = mask_q;
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            if (out_valid_q && OUT_READY) begin
               if (rem_q != '0) begin
                  load     = 1'b1;
                  pick_src = rem_q;
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = HOLD;
         end
         HOLD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Load the lowest pending channel straight into the output registers so
      // masked-off channels cost no cycles.
      if (load) begin
         out_valid_d = 1'b1;
         out_evt_d   = evt_q;
         for (int i = 0; i < NCH; i++) begin
            if (pick_src[i] && !found) begin
               found          = 1'b1;
               out_chan_d     = 3'(i);
               out_integral_d = INTEGRAL_IN[i*AREA_W +: AREA_W];
               out_peak_d     = PEAK_IN[i*ADC_W +: ADC_W];
               out_baseline_d = SBASELINE_IN[i*BL_W +: BL_W];
               out_sat_d      = SATURATED_IN[i];
               rem_d          = pick_src & ~(NCH'(1) << i);
            end
         end
         out_last_d = (rem_d == '0);
      end

      if (TRIG && (state_q != IDLE) && (missed_q != 16'hFFFF))
         missed_d = missed_q + 16'd1;

      integ_en_d = ((state_d == INTEG) || (state_d == READ)) ? '1 : '0;
      evt_done_d = (state_d == DONE);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         mask_q         <= '0;
         rem_q          <= '0;
         evt_q          <= '0;
         missed_q       <= '0;
         integ_en_q     <= '0;
         out_valid_q    <= 1'b0;
         out_chan_q     <= '0;
         out_integral_q <= '0;
         out_peak_q     <= '0;
         out_baseline_q <= '0;
         out_sat_q      <= 1'b0;
         out_last_q     <= 1'b0;
         out_evt_q      <= '0;
         busy_q         <= 1'b0;
         evt_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mask_q         <= mask_d;
         rem_q          <= rem_d;
         evt_q          <= evt_d;
         missed_q       <= missed_d;
         integ_en_q     <= integ_en_d;
         out_valid_q    <= out_valid_d;
         out_chan_q     <= out_chan_d;
         out_integral_q <= out_integral_d;
         out_peak_q     <= out_peak_d;
         out_baseline_q <= out_baseline_d;
         out_sat_q      <= out_sat_d;
         out_last_q     <= out_last_d;
         out_evt_q      <= out_evt_d;
         busy_q         <= busy_d;
         evt_done_q     <= evt_done_d;
      end
   end

   assign INTEG_EN     = integ_en_q;
   assign OUT_VALID    = out_valid_q;
   assign OUT_CHAN     = out_chan_q;
   assign OUT_INTEGRAL = out_integral_q;
   assign OUT_PEAK     = out_peak_q;
   assign OUT_BASELINE = out_baseline_q;
   assign OUT_SAT      = out_sat_q;
   assign OUT_LAST     = out_last_q;
   assign OUT_EVT      = out_evt_q;
   assign BUSY         = busy_q;
   assign EVT_DONE     = evt_done_q;
   assign MISSED       = missed_q;

endmodule

// File: doc/shwr_integral_seq.md
SHWR_INTEGRAL_SEQ -- requirements
Module: shwr_integral_seq

Interface
REQ-001 SHALL have parameter NCH, default 6, number of shower-integral instances (index 2k = PMT k low gain, 2k+1 = PMT k high gain).
REQ-002 SHALL have parameter AREA_W, default 19, integral width; ADC_W, default 12; BL_W, default 14 (baseline incl. extra bits).
REQ-003 SHALL have parameter WINDOW, default 264, cycles INTEG_EN held before readout; HOLDOFF, default 16, cycles INTEG_EN held low after an event.
REQ-004 CLK120  in  1  clock; all logic on rising edge.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 TRIG  in  1  shower trigger pulse, sampled each cycle.
REQ-007 CH_MASK  in  NCH  channel read enable, sampled on trigger acceptance.
REQ-008 INTEGRAL_IN  in  NCH*AREA_W  concatenated instance integrals, channel i at bits [i*AREA_W +: AREA_W].
REQ-009 PEAK_IN  in  NCH*ADC_W; SBASELINE_IN  in  NCH*BL_W; SATURATED_IN  in  NCH -- same packing.
REQ-010 INTEG_EN  out  NCH  TRIGGERED drive to every instance (all bits identical).
REQ-011 HILO  out  NCH  constant: bit i = i mod 2.
REQ-012 OUT_VALID out 1; OUT_READY in 1; OUT_CHAN out 3; OUT_INTEGRAL out AREA_W; OUT_PEAK out ADC_W; OUT_BASELINE out BL_W; OUT_SAT out 1; OUT_LAST out 1; OUT_EVT out 8 -- readout stream.
REQ-013 BUSY out 1 (state != IDLE); EVT_DONE out 1 (one-cycle pulse); MISSED out 16 (dropped-trigger count).

Function
REQ-014 States SHALL be IDLE, INTEG, READ, DONE, HOLD.
REQ-015 IDLE: TRIG=1 SHALL accept: latch CH_MASK, increment event counter (8-bit wrap), clear window counter, go INTEG; INTEG_EN=1 from the next cycle.
REQ-016 INTEG: INTEG_EN SHALL be 1; after exactly WINDOW cycles in INTEG, go READ if latched mask nonzero, else DONE.
REQ-017 INTEG_EN SHALL remain 1 through INTEG and READ (instances clear results when TRIGGERED falls) and go 0 on entry to DONE.
REQ-018 READ: SHALL present lowest-index enabled channel not yet sent; OUT_VALID=1, fields from that channel's slice, OUT_CHAN = index, OUT_EVT = event counter.
REQ-019 OUT_* fields SHALL be registered and stable while OUT_VALID=1 and OUT_READY=0.
REQ-020 Transfer SHALL occur when OUT_VALID & OUT_READY; next cycle presents next enabled channel, or goes DONE with OUT_VALID=0 after the last.
REQ-021 OUT_LAST SHALL be 1 only on the highest-index enabled channel of the latched mask.
REQ-022 Channels with latched mask bit 0 SHALL be skipped without bubble cycles (back-to-back with OUT_READY=1 yields one word per cycle).
REQ-023 DONE: SHALL pulse EVT_DONE for one cycle, go HOLD.
REQ-024 HOLD: SHALL count HOLDOFF cycles with INTEG_EN=0 (baseline re-tracking), then go IDLE.
REQ-025 TRIG=1 in any state other than IDLE SHALL increment MISSED, saturating at 16'hFFFF; no effect on sequencing.
REQ-026 OUT_READY asserted while OUT_VALID=0 SHALL be ignored.
REQ-027 CH_MASK changes after acceptance SHALL not affect the current event.

Reset
REQ-028 RESET SHALL force IDLE from any state, including mid-READ, in the same cycle edge.
REQ-029 Reset values: INTEG_EN=0, OUT_VALID=0, OUT_LAST=0, OUT_CHAN=0, OUT_INTEGRAL=0, OUT_PEAK=0, OUT_BASELINE=0, OUT_SAT=0, OUT_EVT=0, EVT_DONE=0, MISSED=0, event counter=0, counters=0; HILO constant regardless.
REQ-030 TRIG during the RESET cycle SHALL not be accepted or counted.

Verification
REQ-031 Mask 6'h3F, TRIG at cycle 0, OUT_READY=1, WINDOW=264 -> INTEG_EN high cycles 1..270; OUT_CHAN 0..5 on cycles 265..270, OUT_LAST on chan 5, OUT_EVT=1, EVT_DONE cycle 271, BUSY low after 16 HOLD cycles.
REQ-032 Mask 6'b100100, INTEGRAL_IN ch2=19'h1234, ch5=19'h00ABC -> exactly two words: chan 2 (1234, LAST=0), chan 5 (00ABC, LAST=1).
REQ-033 OUT_READY held 0 for 50 cycles on first word -> OUT_VALID and fields stable 50 cycles, INTEG_EN stays 1, no word lost.
REQ-034 Mask 0 -> no OUT_VALID, EVT_DONE one cycle after window ends; 3 TRIG pulses during INTEG/HOLD -> MISSED=3; 70000 pulses while busy -> MISSED=16'hFFFF.
REQ-035 RESET asserted mid-READ after chan 1 -> next cycle OUT_VALID=0, INTEG_EN=0, MISSED=0; subsequent TRIG accepted with OUT_EVT=1.
REQ-036 256 accepted events -> OUT_EVT wraps 8'hFF to 8'h00.
